// File: rtl/alu_issue_pkg.sv
// Shared definitions for the TotalALU issue sequencer: funct codes, FSM states
// and the funct classifier shared with decode.
package alu_issue_pkg;

   localparam logic [5:0] F_NOP  = 6'd0;
   localparam logic [5:0] F_SRL  = 6'd2;
   localparam logic [5:0] F_MFHI = 6'd16;
   localparam logic [5:0] F_MFLO = 6'd18;
   localparam logic [5:0] F_DIVU = 6'd27;
   localparam logic [5:0] F_ADD  = 6'd32;
   localparam logic [5:0] F_SUB  = 6'd34;
   localparam logic [5:0] F_AND  = 6'd36;
   localparam logic [5:0] F_OR   = 6'd37;
   localparam logic [5:0] F_SLT  = 6'd42;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_DIV_WAIT,
      S_RD_LO,
      S_RD_HI,
      S_RESP
   } state_t;

   typedef enum logic [1:0] {
      FC_BAD,
      FC_SINGLE,
      FC_DIV
   } fclass_t;

   function automatic fclass_t classify_funct(input logic [5:0] f);
      case (f)
         F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SRL, F_MFHI, F_MFLO: return FC_SINGLE;
         F_DIVU:                                                 return FC_DIV;
         default:                                                return FC_BAD;
      endcase
   endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request/response and TotalALU-facing signals of the issue sequencer.
// slave: the sequencer; master: pipeline plus the ALU it drives.
interface alu_issue_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic [5:0]  req_funct;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic [31:0] rsp_hi;
   logic        rsp_err;
   logic [31:0] alu_dataA;
   logic [31:0] alu_dataB;
   logic [5:0]  alu_signal;
   logic [31:0] alu_output;

   modport master (
      output req_valid, req_funct, req_a, req_b, rsp_ready, alu_output,
      input  req_ready, rsp_valid, rsp_data, rsp_hi, rsp_err,
             alu_dataA, alu_dataB, alu_signal
   );

   modport slave (
      input  req_valid, req_funct, req_a, req_b, rsp_ready, alu_output,
      output req_ready, rsp_valid, rsp_data, rsp_hi, rsp_err,
             alu_dataA, alu_dataB, alu_signal
   );
endinterface

// File: rtl/alu_funct_class.sv
// Combinational funct classifier: single-cycle, divide or unsupported.
module alu_funct_class
   import alu_issue_pkg::*;
(
   input  logic [5:0] funct,
   output logic       is_single,
   output logic       is_div,
   output logic       is_bad
);
   fclass_t fc;

   assign fc        = classify_funct(funct);
   assign is_single = (fc == FC_SINGLE);
   assign is_div    = (fc == FC_DIV);
   assign is_bad    = (fc == FC_BAD);
endmodule

// File: rtl/alu_issue_ctrl.sv
// Sequencer driving TotalALU for one request at a time; DIVU is expanded into
// DIVU/MFLO/MFHI. Optional perf counters under ALU_PERF_CNT_EN.
module alu_issue_ctrl
   import alu_issue_pkg::*;
#(
   parameter int ALU_LAT    = 1,
   parameter int DIV_CYCLES = 32
) (
   input  logic             clk,
   input  logic             reset,
   alu_issue_ctrl_if.slave  bus,
   output logic             busy
`ifdef ALU_PERF_CNT_EN
   ,
   output logic [31:0]      perf_ops,
   output logic [31:0]      perf_stall
`endif
);
   localparam int CW = $clog2(DIV_CYCLES) + 1;
   localparam logic [CW-1:0] LAT_LD = CW'(ALU_LAT - 1);
   localparam logic [CW-1:0] DIV_LD = CW'(DIV_CYCLES - 1);

   if (ALU_LAT < 1 || DIV_CYCLES < 1 || ALU_LAT > (2 ** CW)) begin : g_bad_param
      $error("alu_issue_ctrl: ALU_LAT and DIV_CYCLES must be >= 1");
   end

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   a_q, a_d, b_q, b_d;
   logic [5:0]    sig_q, sig_d;
   logic          vld_q, vld_d;
   logic [31:0]   data_q, data_d, hi_q, hi_d;
   logic          err_q, err_d;
   logic          rdy_q, busy_q;
   logic          is_single, is_div, is_bad;
   logic          accept, cnt_zero;

   alu_funct_class u_fclass (
      .funct     (bus.req_funct),
      .is_single (is_single),
      .is_div    (is_div),
      .is_bad    (is_bad)
   );

   assign accept   = bus.req_valid && rdy_q;
   assign cnt_zero = (cnt_q == '0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      sig_d   = sig_q;
      vld_d   = vld_q;
      data_d  = data_q;
      hi_d    = hi_q;
      err_d   = err_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (is_bad) begin
                  // rejected without touching the ALU
                  state_d = S_RESP;
                  vld_d   = 1'b1;
                  err_d   = 1'b1;
                  data_d  = '0;
                  hi_d    = '0;
               end else if (is_div && bus.req_b == '0) begin
                  state_d = S_RESP;
                  vld_d   = 1'b1;
                  err_d   = 1'b1;
                  data_d  = '1;
                  hi_d    = bus.req_a;
               end else if (is_div) begin
                  state_d = S_DIV_WAIT;
                  a_d     = bus.req_a;
                  b_d     = bus.req_b;
                  sig_d   = F_DIVU;
                  cnt_d   = DIV_LD;
               end else if (is_single) begin
                  state_d = S_ISSUE;
                  a_d     = bus.req_a;
                  b_d     = bus.req_b;
                  sig_d   = bus.req_funct;
                  cnt_d   = LAT_LD;
               end
            end
         end
         S_ISSUE: begin
            if (cnt_zero) begin
               state_d = S_RESP;
               data_d  = bus.alu_output;
               hi_d    = '0;
               err_d   = 1'b0;
               vld_d   = 1'b1;
               a_d     = '0;
               b_d     = '0;
               sig_d   = F_NOP;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_DIV_WAIT: begin
            if (cnt_zero) begin
               state_d = S_RD_LO;
               sig_d   = F_MFLO;
               cnt_d   = LAT_LD;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_RD_LO: begin
            if (cnt_zero) begin
               state_d = S_RD_HI;
               data_d  = bus.alu_output;
               sig_d   = F_MFHI;
               cnt_d   = LAT_LD;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_RD_HI: begin
            if (cnt_zero) begin
               state_d = S_RESP;
               hi_d    = bus.alu_output;
               err_d   = 1'b0;
               vld_d   = 1'b1;
               a_d     = '0;
               b_d     = '0;
               sig_d   = F_NOP;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_RESP: begin
            if (bus.rsp_ready) begin
               state_d = S_IDLE;
               vld_d   = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sig_q   <= F_NOP;
         vld_q   <= 1'b0;
         data_q  <= '0;
         hi_q    <= '0;
         err_q   <= 1'b0;
         rdy_q   <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sig_q   <= sig_d;
         vld_q   <= vld_d;
         data_q  <= data_d;
         hi_q    <= hi_d;
         err_q   <= err_d;
         rdy_q   <= (state_d == S_IDLE);
         busy_q  <= (state_d != S_IDLE);
      end
   end

   assign bus.req_ready  = rdy_q;
   assign bus.rsp_valid  = vld_q;
   assign bus.rsp_data   = data_q;
   assign bus.rsp_hi     = hi_q;
   assign bus.rsp_err    = err_q;
   assign bus.alu_dataA  = a_q;
   assign bus.alu_dataB  = b_q;
   assign bus.alu_signal = sig_q;
   assign busy           = busy_q;

`ifdef ALU_PERF_CNT_EN
   logic [31:0] ops_q, stall_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ops_q   <= '0;
         stall_q <= '0;
      end else begin
         if (vld_q && bus.rsp_ready)  ops_q   <= ops_q + 32'd1;
         if (vld_q && !bus.rsp_ready) stall_q <= stall_q + 32'd1;
      end
   end

   assign perf_ops   = ops_q;
   assign perf_stall = stall_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural TotalALU, directed vector table,
// randomized ops against a reference model, backpressure and reset-abort.
module tb_alu_issue_ctrl;
   localparam int ALU_LAT    = 1;
   localparam int DIV_CYCLES = 32;

   localparam logic [5:0] C_SRL  = 6'd2;
   localparam logic [5:0] C_MFHI = 6'd16;
   localparam logic [5:0] C_MFLO = 6'd18;
   localparam logic [5:0] C_DIVU = 6'd27;
   localparam logic [5:0] C_ADD  = 6'd32;
   localparam logic [5:0] C_SUB  = 6'd34;
   localparam logic [5:0] C_AND  = 6'd36;
   localparam logic [5:0] C_OR   = 6'd37;
   localparam logic [5:0] C_SLT  = 6'd42;

   logic clk = 1'b0;
   logic rst_n;
   logic busy;
   int   checks = 0;
   int   failures = 0;
   int   exp_ops = 0;
   int   exp_stall = 0;
   logic [31:0] ref_hi = 32'hDEADBEEF;
   logic [31:0] ref_lo = 32'hDEADBEEF;

   always #5 clk = ~clk;

   alu_issue_ctrl_if bus ();

`ifdef ALU_PERF_CNT_EN
   logic [31:0] perf_ops, perf_stall;
`endif

   alu_issue_ctrl #(.ALU_LAT(ALU_LAT), .DIV_CYCLES(DIV_CYCLES)) dut (
      .clk        (clk),
      .reset      (rst_n),
      .bus        (bus),
      .busy       (busy)
`ifdef ALU_PERF_CNT_EN
      ,
      .perf_ops   (perf_ops),
      .perf_stall (perf_stall)
`endif
   );

   // Behavioural TotalALU: combinational datapath, HI/LO valid only after
   // DIVU has been held for DIV_CYCLES consecutive edges.
   logic [31:0] m_hi = 32'hDEADBEEF;
   logic [31:0] m_lo = 32'hDEADBEEF;
   int          m_cnt = 0;
   logic [31:0] alu_out;

   always @(posedge clk) begin
      if (bus.alu_signal == C_DIVU) begin
         m_cnt <= m_cnt + 1;
         if (m_cnt + 1 == DIV_CYCLES && bus.alu_dataB != 32'd0) begin
            m_lo <= bus.alu_dataA / bus.alu_dataB;
            m_hi <= bus.alu_dataA % bus.alu_dataB;
         end
      end else begin
         m_cnt <= 0;
      end
   end

   always_comb begin
      alu_out = '0;
      case (bus.alu_signal)
         C_AND:  alu_out = bus.alu_dataA & bus.alu_dataB;
         C_OR:   alu_out = bus.alu_dataA | bus.alu_dataB;
         C_ADD:  alu_out = bus.alu_dataA + bus.alu_dataB;
         C_SUB:  alu_out = bus.alu_dataA - bus.alu_dataB;
         C_SLT:  alu_out = ($signed(bus.alu_dataA) < $signed(bus.alu_dataB)) ? 32'd1 : 32'd0;
         C_SRL:  alu_out = bus.alu_dataA >> bus.alu_dataB[4:0];
         C_MFHI: alu_out = m_hi;
         C_MFLO: alu_out = m_lo;
         default: alu_out = '0;
      endcase
   end
   assign bus.alu_output = alu_out;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic logic is_known(input logic [5:0] f);
      return f inside {C_AND, C_OR, C_ADD, C_SUB, C_SLT, C_SRL, C_DIVU, C_MFHI, C_MFLO};
   endfunction

   // Expected result from the instruction semantics; tracks HI/LO architecturally.
   function automatic void ref_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] d, output logic [31:0] h,
                                  output logic e, output int lat);
      logic [4:0] sh;
      sh  = b[4:0];
      d   = '0;
      h   = '0;
      e   = 1'b0;
      lat = ALU_LAT;
      case (f)
         C_AND:  d = a & b;
         C_OR:   d = a | b;
         C_ADD:  d = a + b;
         C_SUB:  d = a - b;
         C_SLT:  d = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         C_SRL:  d = a >> sh;
         C_MFHI: d = ref_hi;
         C_MFLO: d = ref_lo;
         C_DIVU: begin
            if (b == 32'd0) begin
               d = '1; h = a; e = 1'b1; lat = 0;
            end else begin
               d = a / b; h = a % b; lat = DIV_CYCLES + 2 * ALU_LAT;
               ref_lo = d; ref_hi = h;
            end
         end
         default: begin e = 1'b1; lat = 0; end
      endcase
   endfunction

   // One full transaction from accept to response handshake; called at a negedge.
   task automatic do_op(input string nm, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] d_exp, input logic [31:0] h_exp, input logic e_exp,
                        input int lat_exp, input int stall);
      int n, lat, nd, nlo, nhi, nf;
      logic bad;
      logic [31:0] held;
      n = 0;
      while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
      chk({nm, ".req_ready"}, 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b1; bus.req_funct = f; bus.req_a = a; bus.req_b = b;
      bus.rsp_ready = 1'b0;
      @(negedge clk);
      bus.req_valid = 1'b0; bus.req_funct = 6'($urandom); bus.req_a = $urandom; bus.req_b = $urandom;
      chk({nm, ".busy"}, 32'({bus.req_ready, busy}), 32'b01);
      if (!e_exp) chk({nm, ".opA"}, bus.alu_dataA, a);
      if (!e_exp) chk({nm, ".opB"}, bus.alu_dataB, b);
      lat = 0; nd = 0; nlo = 0; nhi = 0; nf = 0;
      while (!bus.rsp_valid && lat < 200) begin
         if (bus.alu_signal == C_DIVU) nd++;
         else if (bus.alu_signal == C_MFLO) nlo++;
         else if (bus.alu_signal == C_MFHI) nhi++;
         if (bus.alu_signal == f) nf++;
         @(negedge clk);
         lat++;
      end
      chk({nm, ".latency"}, 32'(lat), 32'(lat_exp));
      if (!e_exp && f == C_DIVU)
         chk({nm, ".div_seq"}, 32'({8'(nd), 8'(nlo), 8'(nhi)}), 32'({8'(DIV_CYCLES), 8'(ALU_LAT), 8'(ALU_LAT)}));
      else if (!e_exp)
         chk({nm, ".issue_seq"}, 32'(nf), 32'(ALU_LAT));
      chk({nm, ".rsp_data"}, bus.rsp_data, d_exp);
      chk({nm, ".rsp_hi"}, bus.rsp_hi, h_exp);
      chk({nm, ".rsp_err"}, 32'(bus.rsp_err), 32'(e_exp));
      chk({nm, ".alu_idle"}, bus.alu_signal | bus.alu_dataA | bus.alu_dataB, 32'd0);
      held = bus.rsp_data; bad = 1'b0;
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         if (!bus.rsp_valid || bus.rsp_data !== held || bus.req_ready) bad = 1'b1;
      end
      if (stall > 0) chk({nm, ".hold"}, 32'(bad), 32'd0);
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      chk({nm, ".after_hs"}, 32'({bus.rsp_valid, bus.req_ready}), 32'b01);
      exp_ops++;
      exp_stall += stall;
   endtask

   typedef struct {
      logic [5:0]  f;
      logic [31:0] a, b, d, h;
      logic        e;
      int          lat;
      int          stall;
   } vec_t;

   vec_t tbl[12];

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0]  f;
      logic [31:0] a, b, d, h;
      logic        e;
      int          lat, stall;

      tbl[0]  = '{C_ADD,  32'd5,          32'd7,          32'd12,         32'd0, 1'b0, 1,  0};
      tbl[1]  = '{C_SUB,  32'd3,          32'd5,          32'hFFFFFFFE,   32'd0, 1'b0, 1,  0};
      tbl[2]  = '{C_SLT,  32'hFFFFFFFF,   32'd1,          32'd1,          32'd0, 1'b0, 1,  0};
      tbl[3]  = '{C_DIVU, 32'd100,        32'd7,          32'd14,         32'd2, 1'b0, 34, 0};
      tbl[4]  = '{C_MFLO, 32'd0,          32'd0,          32'd14,         32'd0, 1'b0, 1,  0};
      tbl[5]  = '{C_MFHI, 32'd0,          32'd0,          32'd2,          32'd0, 1'b0, 1,  0};
      tbl[6]  = '{C_DIVU, 32'd9,          32'd0,          32'hFFFFFFFF,   32'd9, 1'b1, 0,  0};
      tbl[7]  = '{6'h3F,  32'd5,          32'd6,          32'd0,          32'd0, 1'b1, 0,  0};
      tbl[8]  = '{C_AND,  32'hF0F0F0F0,   32'hFF00FF00,   32'hF000F000,   32'd0, 1'b0, 1,  2};
      tbl[9]  = '{C_OR,   32'h0000000F,   32'h000000F0,   32'h000000FF,   32'd0, 1'b0, 1,  0};
      tbl[10] = '{C_SRL,  32'h80000000,   32'd4,          32'h08000000,   32'd0, 1'b0, 1,  1};
      tbl[11] = '{C_ADD,  32'd1,          32'd1,          32'd2,          32'd0, 1'b0, 1,  10};

      rst_n = 1'b0;
      bus.req_valid = 1'b0; bus.req_funct = '0; bus.req_a = '0; bus.req_b = '0;
      bus.rsp_ready = 1'b0;
      #1;
      chk("reset.outputs", 32'({bus.rsp_valid, bus.rsp_err, busy, bus.alu_signal}), 32'd0);
      chk("reset.rsp_data", bus.rsp_data | bus.rsp_hi | bus.alu_dataA | bus.alu_dataB, 32'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset.req_ready", 32'(bus.req_ready), 32'd1);

      for (int i = 0; i < 12; i++)
         do_op($sformatf("vec%0d", i), tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].h,
               tbl[i].e, tbl[i].lat, tbl[i].stall);
      ref_lo = 32'd14;
      ref_hi = 32'd2;

      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 9))
            0: f = C_AND;  1: f = C_OR;   2: f = C_ADD;  3: f = C_SUB;  4: f = C_SLT;
            5: f = C_SRL;  6: f = C_DIVU; 7: f = C_MFHI; 8: f = C_MFLO;
            default: begin
               f = 6'($urandom);
               while (is_known(f)) f = 6'($urandom);
            end
         endcase
         a = $urandom;
         b = $urandom;
         if (f == C_DIVU) begin
            if ($urandom_range(0, 3) == 0) b = 32'd0;
            else if ($urandom_range(0, 1) == 0) b = 32'($urandom_range(1, 1000));
         end
         if (f == C_SLT && $urandom_range(0, 1) == 0) a = ~a;
         stall = int'($urandom_range(0, 3));
         ref_op(f, a, b, d, h, e, lat);
         do_op($sformatf("rnd%0d_f%0d", i, f), f, a, b, d, h, e, lat, stall);
      end

`ifdef ALU_PERF_CNT_EN
      chk("perf.ops", perf_ops, 32'(exp_ops));
      chk("perf.stall", perf_stall, 32'(exp_stall));
`endif

      // Reset in the middle of a divide must abort it and clear every output.
      bus.req_valid = 1'b1; bus.req_funct = C_DIVU; bus.req_a = 32'd50; bus.req_b = 32'd3;
      @(negedge clk);
      bus.req_valid = 1'b0;
      repeat (9) @(posedge clk);
      @(posedge clk);
      #1;
      chk("abort.pre", 32'({busy, bus.alu_signal}), 32'({1'b1, C_DIVU}));
      rst_n = 1'b0;
      #1;
      chk("abort.outputs", 32'({bus.rsp_valid, bus.rsp_err, busy, bus.alu_signal}), 32'd0);
      chk("abort.data", bus.rsp_data | bus.rsp_hi | bus.alu_dataA | bus.alu_dataB, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_ops = 0;
      exp_stall = 0;
      @(negedge clk);
      do_op("post_reset_add", C_ADD, 32'd2, 32'd2, 32'd4, 32'd0, 1'b0, ALU_LAT, 1);

`ifdef ALU_PERF_CNT_EN
      chk("perf.ops_after_reset", perf_ops, 32'(exp_ops));
      chk("perf.stall_after_reset", perf_stall, 32'(exp_stall));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
